// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM receiver datapath: the I/Q sample width, the
// default quantization shift, and the quantize helper that later stages reuse.
package fm_radio_pkg;

  localparam int IQ_SAMPLE_WIDTH = 16;
  localparam int QUANTIZE_WIDTH  = 10;

  // Widest quantized result any stage may request; callers size-cast down.
  localparam int QUANT_MAX_WIDTH = 64;

  // Sign-extend a raw 16-bit sample, then shift it left by `shift`.
  // The result is returned at full width so each caller can keep its own
  // DATA_WIDTH low bits.
  function automatic logic [QUANT_MAX_WIDTH-1:0] quantize(
    input logic [IQ_SAMPLE_WIDTH-1:0] sample,
    input int unsigned                shift
  );
    logic [QUANT_MAX_WIDTH-1:0] ext;
    ext = {{(QUANT_MAX_WIDTH-IQ_SAMPLE_WIDTH){sample[IQ_SAMPLE_WIDTH-1]}}, sample};
    return ext << shift;
  endfunction

endpackage

// File: rtl/iq_pair_buffer.sv
// Two-entry FIFO of quantized {I,Q} pairs. Slot 0 is always the head, so the
// head data comes straight from a register with no read-pointer mux.
module iq_pair_buffer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_i,
  input  logic [W-1:0] wr_q,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head_i,
  output logic [W-1:0] head_q
);

  logic [W-1:0] slot0_i, slot0_q;
  logic [W-1:0] slot1_i, slot1_q;
  logic [1:0]   occ_r;

  // Shift-style storage: writes land in the first free slot, pops move slot 1 forward.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset because the head slot drives the outputs
      // directly and must read as zero while the block is in reset.
      slot0_i <= '0;
      slot0_q <= '0;
      slot1_i <= '0;
      slot1_q <= '0;
      occ_r   <= 2'd0;
    end else begin
      unique case ({wr_en, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            slot0_i <= wr_i;
            slot0_q <= wr_q;
          end else begin
            slot1_i <= wr_i;
            slot1_q <= wr_q;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          slot0_i <= slot1_i;
          slot0_q <= slot1_q;
          occ_r   <= occ_r - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; with one entry the new pair becomes head.
          if (occ_r == 2'd1) begin
            slot0_i <= wr_i;
            slot0_q <= wr_q;
          end else begin
            slot0_i <= slot1_i;
            slot0_q <= slot1_q;
            slot1_i <= wr_i;
            slot1_q <= wr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ    = occ_r;
  assign head_i = slot0_i;
  assign head_q = slot0_q;

endmodule

// File: rtl/iq_unpack.sv
// Pops raw 32-bit words from the input FIFO, splits them into I (low half) and
// Q (high half), quantizes both and streams the pairs out on valid/ready.
// Credit-based prefetch covers the FIFO's one-cycle read latency.
module iq_unpack
  import fm_radio_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int QUANTIZE_WIDTH = fm_radio_pkg::QUANTIZE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [31:0]           in_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic [31:0]           pair_count
);

  logic                  inflight;
  logic                  pop;
  logic [1:0]            occ;
  logic [2:0]            credit_used;
  logic [DATA_WIDTH-1:0] wr_i;
  logic [DATA_WIDTH-1:0] wr_q;

  assign pop = out_valid && out_ready;

  // Pairs buffered plus the read in flight must stay below two after this
  // cycle's pop; the pop term makes the credit return the same cycle.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign in_rd_en    = reset_n && !in_empty && (credit_used < ({2'b00, pop} + 3'd2));

  // The FIFO returns data one cycle after the pop, so remember the issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= in_rd_en;
  end

  assign wr_i = DATA_WIDTH'(quantize(in_dout[IQ_SAMPLE_WIDTH-1:0], QUANTIZE_WIDTH));
  assign wr_q = DATA_WIDTH'(quantize(in_dout[2*IQ_SAMPLE_WIDTH-1:IQ_SAMPLE_WIDTH], QUANTIZE_WIDTH));

  iq_pair_buffer #(
    .W (DATA_WIDTH)
  ) u_buffer (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (inflight),
    .wr_i    (wr_i),
    .wr_q    (wr_q),
    .pop     (pop),
    .occ     (occ),
    .head_i  (i_out),
    .head_q  (q_out)
  );

  assign out_valid = (occ != 2'd0);

  // Count delivered pairs; wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pair_count <= '0;
    else if (pop)  pair_count <= pair_count + 32'd1;
  end

endmodule

// File: doc/iq_unpack.md
# iq_unpack

Front-end stage of the FM receiver datapath, between the input sample FIFO and the complex channel FIR. It pops 32-bit raw words from the input FIFO, splits each into a 16-bit signed I and Q sample, sign-extends and quantizes them to DATA_WIDTH, and presents I/Q pairs on a valid/ready interface. A 2-entry output buffer with credit-based prefetch sustains one pair per clock despite the FIFO's 1-cycle read latency.

## Interface
- DATA_WIDTH, 32: output sample width; must be ≥ 16 + QUANTIZE_WIDTH.
- QUANTIZE_WIDTH, 10: left-shift applied to each sign-extended sample.

- clock  in  1  single clock for all logic.
- reset_n  in  1  reset, asynchronous, active-low.
- in_empty  in  1  input FIFO empty flag.
- in_rd_en  out  1  input FIFO pop; combinational.
- in_dout  in  32  FIFO read data, valid the cycle after in_rd_en.
- out_valid  out  1  output buffer head holds a pair.
- out_ready  in  1  downstream accepts the head pair this cycle.
- i_out  out  DATA_WIDTH  quantized I of head pair.
- q_out  out  DATA_WIDTH  quantized Q of head pair.
- pair_count  out  32  pairs delivered (out_valid && out_ready), wraps at 2^32.

## Operation
- Word format: I = in_dout[15:0], Q = in_dout[31:16], both two's complement (bytes arrive little-endian: b0,b1 = I; b2,b3 = Q).
- Quantize: sign-extend 16 → DATA_WIDTH, then shift left QUANTIZE_WIDTH; keep low DATA_WIDTH bits.
- Credit rule: in_rd_en = !in_empty && (occ + inflight − pop < 2), where occ ∈ {0,1,2} buffered pairs, inflight ∈ {0,1} = registered in_rd_en, pop = out_valid && out_ready.
- Cycle after a pop issue, in_dout is quantized and written to the buffer tail; buffer never overflows by construction.
- Buffer is FIFO-ordered; i_out/q_out always reflect head entry; out_valid = (occ != 0).
- Simultaneous write and pop: both take effect, occ unchanged, order preserved (with occ=1 the new entry becomes head next cycle).
- in_empty rising while a read is in flight: in-flight word still captured; no further issue.
- Output data stable while out_valid && !out_ready.
- pair_count increments by 1 per pop.

## Timing
- Reset (reset_n low, asynchronous): occ=0, inflight=0, out_valid=0, i_out=q_out=0, pair_count=0; in_rd_en=0 while reset_n low regardless of in_empty.
- Reset mid-operation: in-flight word and buffered pairs discarded; the FIFO pop already issued is lost (accepted behaviour).
- Latency: in_rd_en high cycle N → data captured at end of N+1 → out_valid high cycle N+2.
- Throughput: 1 pair/cycle with out_ready held high and FIFO non-empty.
- Backpressure: out_ready low for ≥2 cycles → occ reaches 2, in_rd_en held low; resumes same cycle out_ready returns (combinational credit).
- out_valid and data are registered; in_rd_en is the only combinational output (paths from in_empty, out_ready).

## Structure
- fm_radio_pkg: IQ_SAMPLE_WIDTH = 16, QUANTIZE_WIDTH default, function quantize(logic [15:0]) → logic [DATA_WIDTH-1:0]; shared with later stages using the same quantization.
- One sub-module: iq_pair_buffer (2-entry FIFO of {I,Q}, occ output, write/pop ports); iq_unpack holds credit logic, quantize, counter.

## Test plan
- Single word 32'hFFFE_0001 after reset → one pair i_out=32'h0000_0400, q_out=32'hFFFF_F800; out_valid high exactly 2 cycles after in_rd_en; pair_count=1 after pop.
- Extremes 32'h8000_7FFF → i_out=32'h01FF_FC00, q_out=32'hFE00_0000.
- 100 sequential words with out_ready=1, FIFO never empty → 100 pairs on 100 consecutive cycles, in order, pair_count=100.
- out_ready low 5 cycles mid-stream → in_rd_en low after occ=2, head data stable, no loss or duplication; throughput restored when out_ready returns.
- in_empty toggling every cycle → every popped word emitted exactly once, in order; in_rd_en never high while in_empty=1.
- reset_n pulsed low with occ=2 and a read in flight → all outputs 0 immediately (asynchronous), pair_count=0, next word after release emitted normally.
